merlin_ibus_sram_ctrl: RTL and testbench

- Instruction-bus slave sitting directly upstream of the pre-fetch unit.
- Accepts ireq* fetch requests, reads a single-port synchronous on-chip instruction SRAM, and returns irsp* responses with data or bus error.
- Supports one outstanding request, configurable wait states, a response holding register for irspready back-pressure, and address-range, alignment and privilege checks.

---
 rtl/merlin_ibus_sram_ctrl_pkg.sv | 15 +
 rtl/merlin_ibus_sram_ctrl_if.sv | 37 +++
 rtl/merlin_ibus_sram_ctrl.sv | 94 +++++++++
 tb/tb_merlin_ibus_sram_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merlin_ibus_sram_ctrl_pkg.sv
// Shared definitions for the instruction-bus SRAM controller: bus width,
// privilege encoding and controller state encoding.
package merlin_ibus_sram_ctrl_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [1:0] PRIV_USER = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/merlin_ibus_sram_ctrl_if.sv
// Instruction-bus request/response channel between the pre-fetch unit
// (master) and the SRAM controller (slave).
interface merlin_ibus_sram_ctrl_if;
  import merlin_ibus_sram_ctrl_pkg::*;

  logic               ireqready_o;
  logic               ireqvalid_i;
  logic [1:0]         ireqhpl_i;
  logic [RV_XLEN-1:0] ireqaddr_i;
  logic               irspready_i;
  logic               irspvalid_o;
  logic               irsprerr_o;
  logic [RV_XLEN-1:0] irspdata_o;

  modport slave (
    output ireqready_o,
    input  ireqvalid_i,
    input  ireqhpl_i,
    input  ireqaddr_i,
    input  irspready_i,
    output irspvalid_o,
    output irsprerr_o,
    output irspdata_o
  );

  modport master (
    input  ireqready_o,
    output ireqvalid_i,
    output ireqhpl_i,
    output ireqaddr_i,
    output irspready_i,
    input  irspvalid_o,
    input  irsprerr_o,
    input  irspdata_o
  );

endinterface

// File: rtl/merlin_ibus_sram_ctrl.sv
// Instruction-bus slave in front of a single-port synchronous SRAM: one
// outstanding fetch, optional wait states, range/alignment/privilege checks.
module merlin_ibus_sram_ctrl
  import merlin_ibus_sram_ctrl_pkg::*;
#(
  parameter int unsigned        C_WAIT_STATES = 0,
  parameter logic [RV_XLEN-1:0] C_MEM_BASE    = 32'h0000_0000,
  parameter int unsigned        C_MEM_SIZE_X  = 14,
  parameter logic [RV_XLEN-1:0] C_UMODE_BASE  = 32'h0000_2000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clk_en_i,
  merlin_ibus_sram_ctrl_if.slave  ibus,
  output logic                    sram_ce_o,
  output logic [C_MEM_SIZE_X-3:0] sram_addr_o,
  input  logic [31:0]             sram_rdata_i
);

  localparam logic [2:0] WAIT_LOAD =
    3'((C_WAIT_STATES == 0) ? 0 : (C_WAIT_STATES - 1));

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rd_pend_q;
  logic [RV_XLEN-1:0] rdata_q;
  logic               req_err;
  logic               accept;

  always_comb begin
    req_err = 1'b0;
    if ((ibus.ireqaddr_i >> C_MEM_SIZE_X) != (C_MEM_BASE >> C_MEM_SIZE_X))
      req_err = 1'b1;
    if (ibus.ireqaddr_i[1:0] != 2'b00)
      req_err = 1'b1;
    if ((ibus.ireqhpl_i == PRIV_USER) && (ibus.ireqaddr_i < C_UMODE_BASE))
      req_err = 1'b1;
  end

  assign ibus.ireqready_o = (state_q == IDLE) ||
                            ((state_q == RESP) && ibus.irspready_i);
  assign accept      = ibus.ireqvalid_i && ibus.ireqready_o && clk_en_i;
  assign sram_ce_o   = accept && !req_err;
  assign sram_addr_o = ibus.ireqaddr_i[C_MEM_SIZE_X-1:2];

  // A new accept always restarts the transaction, including the retiring
  // cycle of a previous response in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      state_d = (C_WAIT_STATES == 0) ? RESP : WAIT;
      cnt_d   = WAIT_LOAD;
      err_d   = req_err;
    end else if (clk_en_i) begin
      case (state_q)
        WAIT: begin
          if (cnt_q == 3'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 3'd1;
        end
        RESP: begin
          if (ibus.irspready_i) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
    end else if (clk_en_i) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_pend_q <= sram_ce_o;
      if (rd_pend_q) rdata_q <= sram_rdata_i;
    end
  end

  // SRAM output is live only in the cycle after the read; later the copy in
  // rdata_q keeps the response stable under back-pressure.
  assign ibus.irspvalid_o = (state_q == RESP);
  assign ibus.irsprerr_o  = (state_q == RESP) && err_q;
  assign ibus.irspdata_o  = err_q     ? '0 :
                            rd_pend_q ? sram_rdata_i : rdata_q;

endmodule

// File: tb/tb_merlin_ibus_sram_ctrl.sv
// Directed bench for merlin_ibus_sram_ctrl: a zero-wait and a three-wait
// instance, each fed by a behavioural synchronous SRAM.
module tb_merlin_ibus_sram_ctrl;
  import merlin_ibus_sram_ctrl_pkg::*;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic clk_en = 1'b1;

  always #5 clk = ~clk;

  merlin_ibus_sram_ctrl_if bus0 ();
  merlin_ibus_sram_ctrl_if bus3 ();

  logic        sram_ce0, sram_ce3;
  logic [12:0] sram_addr0, sram_addr3;
  logic [31:0] sram_rdata0 = '0;
  logic [31:0] sram_rdata3 = '0;
  int          reads0 = 0;
  int          n_asserts = 0;
  int          n_fails = 0;
  int          reads_snap;

  logic [31:0] err_addr [6] = '{32'h0000_1000, 32'h0000_2000, 32'h0001_0000,
                                32'h0000_4002, 32'h0000_7FFC, 32'h0000_8000};
  logic [1:0]  err_hpl  [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
  logic        err_exp  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  merlin_ibus_sram_ctrl #(
    .C_WAIT_STATES (0),
    .C_MEM_BASE    (32'h0000_0000),
    .C_MEM_SIZE_X  (15),
    .C_UMODE_BASE  (32'h0000_2000)
  ) dut0 (
    .clk_i        (clk),
    .reset_i      (reset),
    .clk_en_i     (clk_en),
    .ibus         (bus0),
    .sram_ce_o    (sram_ce0),
    .sram_addr_o  (sram_addr0),
    .sram_rdata_i (sram_rdata0)
  );

  merlin_ibus_sram_ctrl #(
    .C_WAIT_STATES (3),
    .C_MEM_BASE    (32'h0000_0000),
    .C_MEM_SIZE_X  (15),
    .C_UMODE_BASE  (32'h0000_2000)
  ) dut3 (
    .clk_i        (clk),
    .reset_i      (reset),
    .clk_en_i     (clk_en),
    .ibus         (bus3),
    .sram_ce_o    (sram_ce3),
    .sram_addr_o  (sram_addr3),
    .sram_rdata_i (sram_rdata3)
  );

  // Each SRAM word holds a signature of its own word address.
  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    return 32'hC0DE_0000 | {19'b0, byte_addr[14:2]};
  endfunction

  always @(posedge clk) begin
    if (sram_ce0) begin
      sram_rdata0 <= mem_word({17'b0, sram_addr0, 2'b00});
      reads0      <= reads0 + 1;
    end
    if (sram_ce3) sram_rdata3 <= mem_word({17'b0, sram_addr3, 2'b00});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit use3, input logic valid,
                               input logic [1:0] hpl, input logic [31:0] addr,
                               input logic rsp_ready);
    if (use3) begin
      bus3.ireqvalid_i = valid;
      bus3.ireqhpl_i   = hpl;
      bus3.ireqaddr_i  = addr;
      bus3.irspready_i = rsp_ready;
      bus0.ireqvalid_i = 1'b0;
      bus0.irspready_i = 1'b1;
    end else begin
      bus0.ireqvalid_i = valid;
      bus0.ireqhpl_i   = hpl;
      bus0.ireqaddr_i  = addr;
      bus0.irspready_i = rsp_ready;
      bus3.ireqvalid_i = 1'b0;
      bus3.irspready_i = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.ireqhpl_i = 2'b11;
    bus0.ireqaddr_i = '0;
    bus3.ireqhpl_i = 2'b11;
    bus3.ireqaddr_i = '0;
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", bus0.ireqready_o, 1);
    checkOutput("rst_valid", bus0.irspvalid_o, 0);
    checkOutput("rst_rerr",  bus0.irsprerr_o, 0);
    checkOutput("rst_data",  bus0.irspdata_o, 0);
    checkOutput("rst_ce",    sram_ce0, 0);
    reset = 1'b0;
    next_cycle();

    // zero wait states, back-to-back fetches
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4000, 1'b1);
    @(negedge clk);
    checkOutput("b2b_ce0",    sram_ce0, 1);
    checkOutput("b2b_addr0",  sram_addr0, 32'h1000);
    checkOutput("b2b_rdy0",   bus0.ireqready_o, 1);
    checkOutput("b2b_valid0", bus0.irspvalid_o, 0);
    next_cycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4004, 1'b1);
    @(negedge clk);
    checkOutput("b2b_valid1", bus0.irspvalid_o, 1);
    checkOutput("b2b_data1",  bus0.irspdata_o, mem_word(32'h4000));
    checkOutput("b2b_rerr1",  bus0.irsprerr_o, 0);
    checkOutput("b2b_ce1",    sram_ce0, 1);
    checkOutput("b2b_addr1",  sram_addr0, 32'h1001);
    checkOutput("b2b_rdy1",   bus0.ireqready_o, 1);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_valid2", bus0.irspvalid_o, 1);
    checkOutput("b2b_data2",  bus0.irspdata_o, mem_word(32'h4004));
    checkOutput("b2b_rdy2",   bus0.ireqready_o, 1);
    checkOutput("b2b_ce2",    sram_ce0, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("b2b_idle", bus0.irspvalid_o, 0);

    // three wait states
    next_cycle();
    applyStimulus(1'b1, 1'b1, 2'b11, 32'h4010, 1'b1);
    @(negedge clk);
    checkOutput("ws_ce",  sram_ce3, 1);
    checkOutput("ws_rdy", bus3.ireqready_o, 1);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) next_cycle();
      @(negedge clk);
      checkOutput($sformatf("ws_valid_c%0d", i), bus3.irspvalid_o, (i == 4));
      checkOutput($sformatf("ws_rdy_c%0d", i), bus3.ireqready_o, (i == 4));
      checkOutput($sformatf("ws_ce_c%0d", i), sram_ce3, 0);
    end
    checkOutput("ws_data", bus3.irspdata_o, mem_word(32'h4010));
    checkOutput("ws_rerr", bus3.irsprerr_o, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("ws_idle", bus3.irspvalid_o, 0);

    // back-pressure for five cycles, then retire with a same-cycle accept
    next_cycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4020, 1'b0);
    @(negedge clk);
    checkOutput("bp_rdy0", bus0.ireqready_o, 1);
    checkOutput("bp_ce0",  sram_ce0, 1);
    next_cycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4024, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) next_cycle();
      @(negedge clk);
      checkOutput($sformatf("bp_valid_c%0d", i), bus0.irspvalid_o, 1);
      checkOutput($sformatf("bp_data_c%0d", i), bus0.irspdata_o, mem_word(32'h4020));
      checkOutput($sformatf("bp_rdy_c%0d", i), bus0.ireqready_o, 0);
      checkOutput($sformatf("bp_ce_c%0d", i), sram_ce0, 0);
    end
    next_cycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4024, 1'b1);
    @(negedge clk);
    checkOutput("bp_ret_valid", bus0.irspvalid_o, 1);
    checkOutput("bp_ret_data",  bus0.irspdata_o, mem_word(32'h4020));
    checkOutput("bp_ret_rdy",   bus0.ireqready_o, 1);
    checkOutput("bp_ret_ce",    sram_ce0, 1);
    checkOutput("bp_ret_addr",  sram_addr0, 32'h1009);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("bp_new_valid", bus0.irspvalid_o, 1);
    checkOutput("bp_new_data",  bus0.irspdata_o, mem_word(32'h4024));
    next_cycle();
    @(negedge clk);
    checkOutput("bp_idle", bus0.irspvalid_o, 0);

    // error and boundary cases
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      applyStimulus(1'b0, 1'b1, err_hpl[i], err_addr[i], 1'b1);
      @(negedge clk);
      checkOutput($sformatf("chk%0d_ce", i), sram_ce0, !err_exp[i]);
      checkOutput($sformatf("chk%0d_rdy", i), bus0.ireqready_o, 1);
      next_cycle();
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("chk%0d_valid", i), bus0.irspvalid_o, 1);
      checkOutput($sformatf("chk%0d_rerr", i), bus0.irsprerr_o, err_exp[i]);
      checkOutput($sformatf("chk%0d_data", i), bus0.irspdata_o,
                  err_exp[i] ? 32'h0 : mem_word(err_addr[i]));
    end

    // clock-enable stalls around a zero-wait read
    next_cycle();
    reads_snap = reads0;
    clk_en = 1'b0;
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4030, 1'b1);
    @(negedge clk);
    checkOutput("ce_off_ce", sram_ce0, 0);
    next_cycle();
    clk_en = 1'b1;
    @(negedge clk);
    checkOutput("ce_on_ce", sram_ce0, 1);
    next_cycle();
    clk_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("ce_s1_valid", bus0.irspvalid_o, 1);
    checkOutput("ce_s1_data",  bus0.irspdata_o, mem_word(32'h4030));
    next_cycle();
    clk_en = 1'b1;
    @(negedge clk);
    checkOutput("ce_s2_valid", bus0.irspvalid_o, 1);
    checkOutput("ce_s2_data",  bus0.irspdata_o, mem_word(32'h4030));
    next_cycle();
    clk_en = 1'b0;
    @(negedge clk);
    checkOutput("ce_s3_valid", bus0.irspvalid_o, 1);
    checkOutput("ce_s3_data",  bus0.irspdata_o, mem_word(32'h4030));
    next_cycle();
    clk_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("ce_s4_valid", bus0.irspvalid_o, 1);
    checkOutput("ce_s4_data",  bus0.irspdata_o, mem_word(32'h4030));
    next_cycle();
    @(negedge clk);
    checkOutput("ce_idle",  bus0.irspvalid_o, 0);
    checkOutput("ce_reads", reads0 - reads_snap, 1);

    // asynchronous reset in the cycle after an accept
    next_cycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'h4040, 1'b0);
    @(negedge clk);
    checkOutput("ar_ce", sram_ce0, 1);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b0);
    #1;
    checkOutput("ar_pre_valid", bus0.irspvalid_o, 1);
    reset = 1'b1;
    #1;
    checkOutput("ar_valid", bus0.irspvalid_o, 0);
    checkOutput("ar_rdy",   bus0.ireqready_o, 1);
    checkOutput("ar_data",  bus0.irspdata_o, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("ar_post_valid_c%0d", i), bus0.irspvalid_o, 0);
      checkOutput($sformatf("ar_post_rdy_c%0d", i), bus0.ireqready_o, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
